// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts rising edges of spike_in over a programmable window of cycles and
// offers the count on a valid/ready port. Optional continuous mode: SPIKE_DECODE_CONTINUOUS_EN.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_W = 8,
  parameter int unsigned COUNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                spike_in,
  output logic [COUNT_W-1:0]  rate,
  output logic                rate_valid,
  input  logic                rate_ready,
  output logic                sat,
  output logic                busy
`ifdef SPIKE_DECODE_CONTINUOUS_EN
  ,
  output logic                overrun
`endif
);

  typedef enum logic [1:0] {StIdle, StCount, StHold} state_t;

  localparam logic [COUNT_W-1:0]  CntMax = '1;
  localparam logic [COUNT_W-1:0]  CntOne = COUNT_W'(1);
  localparam logic [WINDOW_W-1:0] CycOne = WINDOW_W'(1);

  state_t              state_q;
  logic                spike_q;
  logic [WINDOW_W-1:0] len_q;
  logic [WINDOW_W-1:0] cyc_q;
  logic [COUNT_W-1:0]  cnt_q;
  logic                flag_q;

  logic                spike_edge;
  logic                cnt_full;
  logic [WINDOW_W-1:0] cyc_next;
  logic [COUNT_W-1:0]  cnt_next;
  logic                flag_next;
  logic                start_ok;
  logic                accept;

  always_comb begin
    spike_edge = spike_in & ~spike_q;
    cnt_full   = (cnt_q == CntMax);
    cyc_next   = cyc_q + CycOne;
    cnt_next   = (spike_edge && !cnt_full) ? cnt_q + CntOne : cnt_q;
    // An edge arriving while the counter is already full marks the window as saturated.
    flag_next  = flag_q | (spike_edge & cnt_full);
    start_ok   = enable && (window_len != '0);
    accept     = rate_valid & rate_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      spike_q    <= 1'b0;
      len_q      <= '0;
      cyc_q      <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      sat        <= 1'b0;
      busy       <= 1'b0;
`ifdef SPIKE_DECODE_CONTINUOUS_EN
      overrun    <= 1'b0;
`endif
    end else begin
      spike_q <= spike_in;
      if (accept) begin
        rate_valid <= 1'b0;
`ifdef SPIKE_DECODE_CONTINUOUS_EN
        overrun    <= 1'b0;
`endif
      end
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            len_q   <= window_len;
            cyc_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            state_q <= StCount;
            busy    <= 1'b1;
          end
        end
        StCount: begin
          if (!enable) begin
            // Abort discards the partial window; any published result is untouched.
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (cyc_next == len_q) begin
            rate       <= cnt_next;
            sat        <= flag_next;
            rate_valid <= 1'b1;
`ifdef SPIKE_DECODE_CONTINUOUS_EN
            // Stay in COUNT so the next window starts without a gap.
            if (rate_valid && !rate_ready) overrun <= 1'b1;
            cyc_q  <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
`else
            state_q <= StHold;
            busy    <= 1'b0;
`endif
          end else begin
            cyc_q  <= cyc_next;
            cnt_q  <= cnt_next;
            flag_q <= flag_next;
          end
        end
        StHold: begin
          if (accept) begin
            if (start_ok) begin
              len_q   <= window_len;
              cyc_q   <= '0;
              cnt_q   <= '0;
              flag_q  <= 1'b0;
              state_q <= StCount;
              busy    <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: directed windows push expected rate/sat words,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_spike_rate_decoder;

  localparam int unsigned WindowW = 8;
  localparam int unsigned CountW  = 6;

  typedef struct packed {
    logic [CountW-1:0] rate;
    logic              sat;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               enable;
  logic [WindowW-1:0] window_len;
  logic               spike_in;
  logic [CountW-1:0]  rate;
  logic               rate_valid;
  logic               rate_ready;
  logic               sat;
  logic               busy;
`ifdef SPIKE_DECODE_CONTINUOUS_EN
  logic               overrun;
`endif

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  spike_rate_decoder #(
    .WINDOW_W(WindowW),
    .COUNT_W (CountW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .window_len(window_len),
    .spike_in  (spike_in),
    .rate      (rate),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .sat       (sat),
    .busy      (busy)
`ifdef SPIKE_DECODE_CONTINUOUS_EN
    ,
    .overrun   (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a handshake completes at the next rising edge when valid & ready hold now.
  always @(negedge clk) begin
    if (!rst && rate_valid && rate_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_rate", int'(rate), int'(e.rate));
        check("sb_sat", int'(sat), int'(e.sat));
      end
    end
  end

  // pat[c] is spike_in during counted cycle c (1-based); starts and ends in IDLE.
  task automatic run_window(input int len, input logic [255:0] pat, input int exp_rate,
                            input int exp_sat, input int hold);
    exp_t e;
    e.rate = CountW'(exp_rate);
    e.sat  = exp_sat[0];
    exp_q.push_back(e);
    window_len = WindowW'(len);
    enable     = 1'b1;
    rate_ready = 1'b0;
    tick(1);
    check("busy_on_start", int'(busy), 1);
    for (int c = 1; c <= len; c++) begin
      spike_in = pat[c];
      if (c == len) check("valid_early", int'(rate_valid), 0);
      tick(1);
    end
    spike_in = 1'b0;
    check("valid_latency", int'(rate_valid), 1);
    tick(hold);
    check("rate_held", int'(rate), exp_rate);
    check("valid_held", int'(rate_valid), 1);
    enable     = 1'b0;
    rate_ready = 1'b1;
    tick(1);
    rate_ready = 1'b0;
    check("valid_cleared", int'(rate_valid), 0);
    check("busy_idle", int'(busy), 0);
  endtask

  logic [255:0] pat;
  logic [15:0]  spk;
  int           vcount;

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    window_len = '0;
    spike_in   = 1'b0;
    rate_ready = 1'b0;
    #3;
    check("rst_rate", int'(rate), 0);
    check("rst_valid", int'(rate_valid), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // Basic count: spikes on counted cycles 2, 5, 9, held unaccepted for a while.
    pat = '0; pat[2] = 1'b1; pat[5] = 1'b1; pat[9] = 1'b1;
    run_window(10, pat, 3, 0, 4);

    // Level vs edge: high over 3..8 is one spike; a spike on the last cycle counts.
    pat = '0;
    for (int c = 3; c <= 8; c++) pat[c] = 1'b1;
    pat[10] = 1'b1;
    run_window(10, pat, 2, 0, 1);
    pat = '0; pat[10] = 1'b1;
    run_window(10, pat, 1, 0, 0);

    // Saturation: 100 edges into a 6-bit counter, then a clean 5-spike window.
    pat = '0;
    for (int c = 1; c <= 200; c++) pat[c] = c[0];
    run_window(200, pat, 63, 1, 2);
    pat = '0;
    for (int c = 1; c <= 9; c += 2) pat[c] = 1'b1;
    run_window(10, pat, 5, 0, 0);

    // Abort at counted cycle 4: partial window discarded, last result stays.
    window_len = 8'd10;
    enable     = 1'b1;
    tick(1);
    for (int c = 1; c <= 3; c++) begin
      spike_in = (c == 2);
      tick(1);
    end
    enable = 1'b0;
    tick(1);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(rate_valid), 0);
    check("abort_rate", int'(rate), 5);
    check("abort_sat", int'(sat), 0);

    // Zero length never leaves IDLE.
    window_len = '0;
    enable     = 1'b1;
    tick(3);
    check("zero_len_busy", int'(busy), 0);
    check("zero_len_valid", int'(rate_valid), 0);
    enable = 1'b0;
    tick(1);

`ifndef SPIKE_DECODE_CONTINUOUS_EN
    // Back-to-back with ready high: windows at t=1-4, 6-9, 11-14; HOLD at t=5, 10, 15.
    spk = '0; spk[2] = 1'b1; spk[5] = 1'b1; spk[7] = 1'b1; spk[9] = 1'b1; spk[12] = 1'b1;
    exp_q.push_back(exp_t'{rate: 6'd1, sat: 1'b0});
    exp_q.push_back(exp_t'{rate: 6'd2, sat: 1'b0});
    exp_q.push_back(exp_t'{rate: 6'd1, sat: 1'b0});
    vcount     = 0;
    rate_ready = 1'b1;
    window_len = 8'd4;
    enable     = 1'b1;
    tick(1);
    for (int t = 1; t <= 15; t++) begin
      spike_in = spk[t];
      if (t == 15) enable = 1'b0;
      if (rate_valid) vcount++;
      tick(1);
    end
    spike_in   = 1'b0;
    rate_ready = 1'b0;
    check("b2b_valid_pulses", vcount, 3);
    check("b2b_busy", int'(busy), 0);
    check("b2b_valid_end", int'(rate_valid), 0);
`endif

    // Async reset mid-COUNT, between clock edges.
    window_len = 8'd10;
    enable     = 1'b1;
    tick(1);
    spike_in = 1'b1;
    tick(1);
    spike_in = 1'b0;
    tick(1);
    check("pre_rst_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_rate", int'(rate), 0);
    check("async_rst_valid", int'(rate_valid), 0);
    check("async_rst_sat", int'(sat), 0);
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    tick(1);
    pat = '0; pat[2] = 1'b1; pat[4] = 1'b1;
    run_window(6, pat, 2, 0, 0);

`ifdef SPIKE_DECODE_CONTINUOUS_EN
    // Continuous: windows t=1-4 and 5-8 with no gap; the unread first result is overrun.
    spk = '0; spk[2] = 1'b1; spk[5] = 1'b1; spk[7] = 1'b1;
    exp_q.push_back(exp_t'{rate: 6'd2, sat: 1'b0});
    rate_ready = 1'b0;
    window_len = 8'd4;
    enable     = 1'b1;
    tick(1);
    for (int t = 1; t <= 8; t++) begin
      spike_in = spk[t];
      tick(1);
    end
    spike_in = 1'b0;
    check("cont_overrun_set", int'(overrun), 1);
    check("cont_rate", int'(rate), 2);
    check("cont_busy", int'(busy), 1);
    enable     = 1'b0;
    rate_ready = 1'b1;
    tick(1);
    rate_ready = 1'b0;
    check("cont_overrun_clr", int'(overrun), 0);
    check("cont_valid_clr", int'(rate_valid), 0);
    check("cont_abort_busy", int'(busy), 0);
`endif

    tick(2);
    check("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
